// File: rtl/com_dpram_mailbox_if.sv
// Avalon-MM slave-side bundle for one port of the shared mailbox memory.
// The master modport is the processor's view; the slave modport is the memory's view.
interface com_dpram_mailbox_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic                  irq;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest, irq
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest, irq
    );
endinterface

// File: rtl/com_dpram_mailbox.sv
// Dual-port shared memory between two Avalon-MM masters, with a doorbell word at the
// top address that interrupts the opposite side when written.
module com_dpram_mailbox #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
    input logic                clk,
    input logic                reset,
    com_dpram_mailbox_if.slave a,
    com_dpram_mailbox_if.slave b
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MBOX = '1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("com_dpram_mailbox: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
        $error("com_dpram_mailbox: DATA_WIDTH must be a multiple of 8 in 8..128");
    end

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic a_req, b_req, collision;
    logic a_wr, a_rd, b_wr, b_rd;

    logic [READ_LATENCY-1:0] a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [DATA_WIDTH-1:0]   a_dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   a_dat_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   b_dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   b_dat_d [READ_LATENCY];
    logic                    a_irq_q, a_irq_d, b_irq_q, b_irq_d;

    // Port A always wins a same-address conflict involving a write; B is held off until clear.
    always_comb begin
        a_req     = a.chipselect & (a.read | a.write);
        b_req     = b.chipselect & (b.read | b.write);
        collision = a_req & b_req & (a.address == b.address) & (a.write | b.write);
        a_wr      = a_req & ~reset & a.write;
        a_rd      = a_req & ~reset & a.read & ~a.write;
        b_wr      = b_req & ~reset & ~collision & b.write;
        b_rd      = b_req & ~reset & ~collision & b.read & ~b.write;
    end

    assign a.waitrequest = 1'b0;
    assign b.waitrequest = collision & ~reset;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (a_wr && a.byteenable[i]) ram[a.address][i*8 +: 8] <= a.writedata[i*8 +: 8];
            if (b_wr && b.byteenable[i]) ram[b.address][i*8 +: 8] <= b.writedata[i*8 +: 8];
        end
    end

    // Each stage only captures when the stage before holds a read, so the last stage keeps
    // the most recent returned word between strobes.
    always_comb begin
        a_vld_d    = a_vld_q;
        b_vld_d    = b_vld_q;
        a_dat_d    = a_dat_q;
        b_dat_d    = b_dat_q;
        a_vld_d[0] = a_rd;
        b_vld_d[0] = b_rd;
        a_dat_d[0] = a_rd ? ram[a.address] : a_dat_q[0];
        b_dat_d[0] = b_rd ? ram[b.address] : b_dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            a_vld_d[i] = a_vld_q[i-1];
            b_vld_d[i] = b_vld_q[i-1];
            a_dat_d[i] = a_vld_q[i-1] ? a_dat_q[i-1] : a_dat_q[i];
            b_dat_d[i] = b_vld_q[i-1] ? b_dat_q[i-1] : b_dat_q[i];
        end
    end

    // Doorbell: a write to the mailbox from one side rings the other; setting beats clearing.
    always_comb begin
        a_irq_d = a_irq_q;
        b_irq_d = b_irq_q;
        if (b_wr && b.address == MBOX) begin
            a_irq_d = 1'b1;
        end else if (a_rd && a.address == MBOX) begin
            a_irq_d = 1'b0;
        end
        if (a_wr && a.address == MBOX) begin
            b_irq_d = 1'b1;
        end else if (b_rd && b.address == MBOX) begin
            b_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q <= '0;
            b_vld_q <= '0;
            a_irq_q <= 1'b0;
            b_irq_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                a_dat_q[i] <= '0;
                b_dat_q[i] <= '0;
            end
        end else begin
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            a_dat_q <= a_dat_d;
            b_dat_q <= b_dat_d;
            a_irq_q <= a_irq_d;
            b_irq_q <= b_irq_d;
        end
    end

    assign a.readdatavalid = a_vld_q[READ_LATENCY-1];
    assign b.readdatavalid = b_vld_q[READ_LATENCY-1];
    assign a.readdata      = a_dat_q[READ_LATENCY-1];
    assign b.readdata      = b_dat_q[READ_LATENCY-1];
    assign a.irq           = a_irq_q;
    assign b.irq           = b_irq_q;
endmodule
